task_dispatch_queue: RTL and testbench

Descriptor FIFO sitting directly upstream of the instruction scheduler. It accepts task descriptors (opcode, source and destination addresses, two parameters) from the host/command interface and tags each with a sequential task ID. It presents the head entry on the scheduler's task_start/task_ready inputs and pops it when the scheduler's one-cycle task_valid acknowledge returns. It also exposes occupancy, issue counters and sticky error flags.

---
 rtl/task_dispatch_queue.sv | 164 ++++++++++++++++
 tb/tb_task_dispatch_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/task_dispatch_queue.sv
// Descriptor FIFO feeding the instruction scheduler: tags pushes with sequential IDs and offers the head.
// Optional macro TASK_QUEUE_OPCODE_CHECK_EN drops opcode-7 pushes and raises a sticky err_illegal_opcode.
module task_dispatch_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [2:0]       host_opcode,
    input  logic [31:0]      host_src_addr,
    input  logic [31:0]      host_dst_addr,
    input  logic [31:0]      host_param1,
    input  logic [31:0]      host_param2,
    input  logic             flush,
    output logic             task_start,
    output logic             task_ready,
    output logic [31:0]      task_id,
    output logic [2:0]       opcode,
    output logic [31:0]      src_addr,
    output logic [31:0]      dst_addr,
    output logic [31:0]      param1,
    output logic [31:0]      param2,
    input  logic             task_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [31:0]      issued_count,
    output logic             err_spurious_ack,
    output logic             err_illegal_opcode
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] id;
        logic [2:0]  op;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] p1;
        logic [31:0] p2;
    } desc_t;

    state_t             state_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]        next_id_q;
    logic [31:0]        issued_q;
    logic               err_spur_q;
    desc_t              mem_q [DEPTH];
    desc_t              head;

    logic push_fire;
    logic enq;
    logic pop;
    logic spurious;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign host_ready = !full && !flush;
    assign push_fire  = host_valid && host_ready;

`ifdef TASK_QUEUE_OPCODE_CHECK_EN
    assign enq = push_fire && (host_opcode != 3'd7);
`else
    assign enq = push_fire;
`endif

    // A flush swallows any acknowledge arriving in the same cycle.
    assign pop      = task_valid && (state_q == OFFER) && !empty && !flush;
    assign spurious = task_valid && ((state_q == IDLE) || empty);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({enq, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // The offer state follows the next occupancy, so a pop with a same-cycle push keeps offering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            next_id_q  <= '0;
            issued_q   <= '0;
            err_spur_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (count_d != '0) state_q <= OFFER;
                OFFER:   if (count_d == '0) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (enq)      next_id_q  <= next_id_q + 32'd1;
            if (pop)      issued_q   <= issued_q + 32'd1;
            if (spurious) err_spur_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= '{id:  next_id_q,
                                 op:  host_opcode,
                                 src: host_src_addr,
                                 dst: host_dst_addr,
                                 p1:  host_param1,
                                 p2:  host_param2};
        end
    end

`ifdef TASK_QUEUE_OPCODE_CHECK_EN
    logic err_ill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ill_q <= 1'b0;
        end else if (push_fire && (host_opcode == 3'd7)) begin
            err_ill_q <= 1'b1;
        end
    end

    assign err_illegal_opcode = err_ill_q;
`else
    assign err_illegal_opcode = 1'b0;
`endif

    assign head         = mem_q[rd_ptr_q];
    assign task_start   = (state_q == OFFER);
    assign task_ready   = task_start;
    assign task_id      = task_start ? head.id  : 32'd0;
    assign opcode       = task_start ? head.op  : 3'd0;
    assign src_addr     = task_start ? head.src : 32'd0;
    assign dst_addr     = task_start ? head.dst : 32'd0;
    assign param1       = task_start ? head.p1  : 32'd0;
    assign param2       = task_start ? head.p2  : 32'd0;
    assign count        = count_q;
    assign issued_count = issued_q;
    assign err_spurious_ack = err_spur_q;

endmodule

// File: tb/tb_task_dispatch_queue.sv
// Directed bench for task_dispatch_queue (DEPTH = 8); expected values are hand-computed per scenario.
module tb_task_dispatch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [2:0]  host_opcode = '0;
    logic [31:0] host_src_addr = '0;
    logic [31:0] host_dst_addr = '0;
    logic [31:0] host_param1 = '0;
    logic [31:0] host_param2 = '0;
    logic        flush = 1'b0;
    logic        task_start;
    logic        task_ready;
    logic [31:0] task_id;
    logic [2:0]  opcode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] param1;
    logic [31:0] param2;
    logic        task_valid = 1'b0;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [31:0] issued_count;
    logic        err_spurious_ack;
    logic        err_illegal_opcode;

    int total = 0;
    int bad = 0;

    task_dispatch_queue #(.DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid(host_valid), .host_ready(host_ready), .host_opcode(host_opcode),
        .host_src_addr(host_src_addr), .host_dst_addr(host_dst_addr),
        .host_param1(host_param1), .host_param2(host_param2),
        .flush(flush),
        .task_start(task_start), .task_ready(task_ready), .task_id(task_id),
        .opcode(opcode), .src_addr(src_addr), .dst_addr(dst_addr),
        .param1(param1), .param2(param2),
        .task_valid(task_valid),
        .count(count), .full(full), .empty(empty),
        .issued_count(issued_count),
        .err_spurious_ack(err_spurious_ack),
        .err_illegal_opcode(err_illegal_opcode)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input logic [2:0] op, input logic [31:0] src, input logic [31:0] dst,
                             input logic [31:0] p1, input logic [31:0] p2);
        host_valid    = 1'b1;
        host_opcode   = op;
        host_src_addr = src;
        host_dst_addr = dst;
        host_param1   = p1;
        host_param2   = p2;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        task_valid = 1'b1;
        tick();
        task_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL reset_host_ready got=%b want=1", host_ready); end
        total++; if ({task_start, task_ready} !== 2'b00) begin bad++; $display("FAIL reset_task_start got=%b want=00", {task_start, task_ready}); end
        total++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_occupancy got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
        total++; if (issued_count !== 32'd0) begin bad++; $display("FAIL reset_issued got=%0d want=0", issued_count); end
        total++; if ({err_spurious_ack, err_illegal_opcode} !== 2'b00) begin bad++; $display("FAIL reset_errors got=%b want=00", {err_spurious_ack, err_illegal_opcode}); end
        total++; if ({task_id, opcode, src_addr, dst_addr, param1, param2} !== '0) begin bad++; $display("FAIL reset_fields got id=%0h op=%0d want all zero", task_id, opcode); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        push_desc(3'd1, 32'h100, 32'h200, 32'd5, 32'd6);
        total++; if (task_start !== 1'b1 || task_ready !== 1'b1) begin bad++; $display("FAIL single_start got=%b/%b want=1/1", task_start, task_ready); end
        total++; if (task_id !== 32'd0) begin bad++; $display("FAIL single_id got=%0d want=0", task_id); end
        total++; if (opcode !== 3'd1 || src_addr !== 32'h100 || dst_addr !== 32'h200 || param1 !== 32'd5 || param2 !== 32'd6)
            begin bad++; $display("FAIL single_fields got op=%0d src=%0h dst=%0h p1=%0d p2=%0d want 1/100/200/5/6", opcode, src_addr, dst_addr, param1, param2); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
        pulse_ack();
        total++; if (empty !== 1'b1 || task_start !== 1'b0) begin bad++; $display("FAIL single_pop got empty=%b start=%b want 1/0", empty, task_start); end
        total++; if (issued_count !== 32'd1) begin bad++; $display("FAIL single_issued got=%0d want=1", issued_count); end
        total++; if (opcode !== 3'd0 || task_id !== 32'd0) begin bad++; $display("FAIL single_idle_fields got op=%0d id=%0d want 0/0", opcode, task_id); end
    endtask

    // IDs 1..8 go in; the 9th push must be refused.
    task automatic test_fill();
        for (int i = 0; i < 8; i++) push_desc(3'(i), 32'h1000 + 32'(i), 32'h2000, 32'(i), 32'd0);
        total++; if (full !== 1'b1 || host_ready !== 1'b0 || count !== 4'd8)
            begin bad++; $display("FAIL fill_full got full=%b ready=%b count=%0d want 1/0/8", full, host_ready, count); end
        push_desc(3'd3, 32'hdead, 32'hbeef, 32'd9, 32'd9);
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_ninth got count=%0d want=8", count); end
        for (int i = 0; i < 8; i++) begin
            total++; if (task_start !== 1'b1 || task_id !== 32'(i + 1) || src_addr !== 32'h1000 + 32'(i))
                begin bad++; $display("FAIL fill_order%0d got start=%b id=%0d src=%0h want 1/%0d/%0h", i, task_start, task_id, src_addr, i + 1, 32'h1000 + 32'(i)); end
            pulse_ack();
        end
        total++; if (empty !== 1'b1 || task_start !== 1'b0 || issued_count !== 32'd9)
            begin bad++; $display("FAIL fill_drained got empty=%b start=%b issued=%0d want 1/0/9", empty, task_start, issued_count); end
    endtask

    // IDs 9..11 queued; concurrent ack and push (ID 12) at count 3.
    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) push_desc(3'd2, 32'(i), 32'd0, 32'd0, 32'd0);
        total++; if (count !== 4'd3 || task_id !== 32'd9) begin bad++; $display("FAIL b2b_setup got count=%0d id=%0d want 3/9", count, task_id); end
        task_valid = 1'b1;
        push_desc(3'd4, 32'h44, 32'd0, 32'd0, 32'd0);
        task_valid = 1'b0;
        total++; if (count !== 4'd3 || task_start !== 1'b1 || task_id !== 32'd10)
            begin bad++; $display("FAIL b2b_concurrent got count=%0d start=%b id=%0d want 3/1/10", count, task_start, task_id); end
        for (int i = 0; i < 3; i++) begin
            total++; if (task_start !== 1'b1 || task_id !== 32'(10 + i))
                begin bad++; $display("FAIL b2b_drain%0d got start=%b id=%0d want 1/%0d", i, task_start, task_id, 10 + i); end
            pulse_ack();
        end
        total++; if (issued_count !== 32'd13 || empty !== 1'b1) begin bad++; $display("FAIL b2b_issued got issued=%0d empty=%b want 13/1", issued_count, empty); end
    endtask

    task automatic test_spurious();
        total++; if (err_spurious_ack !== 1'b0) begin bad++; $display("FAIL spur_before got=%b want=0", err_spurious_ack); end
        pulse_ack();
        total++; if (err_spurious_ack !== 1'b1) begin bad++; $display("FAIL spur_set got=%b want=1", err_spurious_ack); end
        total++; if (count !== 4'd0 || issued_count !== 32'd13) begin bad++; $display("FAIL spur_nochange got count=%0d issued=%0d want 0/13", count, issued_count); end
        tick();
        tick();
        total++; if (err_spurious_ack !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b want=1", err_spurious_ack); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) push_desc(3'd5, 32'(i), 32'd0, 32'd0, 32'd0);
        pulse_ack();
        total++; if (count !== 4'd3 || issued_count !== 32'd1) begin bad++; $display("FAIL flush_setup got count=%0d issued=%0d want 3/1", count, issued_count); end
        flush = 1'b1; host_valid = 1'b1; task_valid = 1'b1; host_opcode = 3'd6;
        #1;
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", host_ready); end
        @(posedge clk); #1;
        flush = 1'b0; host_valid = 1'b0; task_valid = 1'b0;
        total++; if (count !== 4'd0 || task_start !== 1'b0 || empty !== 1'b1)
            begin bad++; $display("FAIL flush_clear got count=%0d start=%b empty=%b want 0/0/1", count, task_start, empty); end
        total++; if (issued_count !== 32'd1 || err_spurious_ack !== 1'b0)
            begin bad++; $display("FAIL flush_counters got issued=%0d spur=%b want 1/0", issued_count, err_spurious_ack); end
        push_desc(3'd3, 32'h55, 32'd0, 32'd0, 32'd0);
        total++; if (task_start !== 1'b1 || task_id !== 32'd4 || src_addr !== 32'h55)
            begin bad++; $display("FAIL flush_next_id got start=%b id=%0d src=%0h want 1/4/55", task_start, task_id, src_addr); end
    endtask

    task automatic test_async_reset();
        push_desc(3'd1, 32'd1, 32'd0, 32'd0, 32'd0);
        total++; if (count !== 4'd2) begin bad++; $display("FAIL areset_setup got count=%0d want=2", count); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (count !== 4'd0 || task_start !== 1'b0 || issued_count !== 32'd0)
            begin bad++; $display("FAIL areset_immediate got count=%0d start=%b issued=%0d want 0/0/0", count, task_start, issued_count); end
        tick();
        rst_n = 1'b1;
        tick();
        push_desc(3'd2, 32'd7, 32'd0, 32'd0, 32'd0);
        total++; if (task_id !== 32'd0 || count !== 4'd1) begin bad++; $display("FAIL areset_id got id=%0d count=%0d want 0/1", task_id, count); end
    endtask

    task automatic test_opcode();
        do_reset();
        push_desc(3'd7, 32'h70, 32'd0, 32'd0, 32'd0);
`ifdef TASK_QUEUE_OPCODE_CHECK_EN
        total++; if (err_illegal_opcode !== 1'b1) begin bad++; $display("FAIL opc_flag got=%b want=1", err_illegal_opcode); end
`else
        total++; if (err_illegal_opcode !== 1'b0) begin bad++; $display("FAIL opc_flag got=%b want=0", err_illegal_opcode); end
`endif
        push_desc(3'd2, 32'h20, 32'd0, 32'd0, 32'd0);
`ifdef TASK_QUEUE_OPCODE_CHECK_EN
        total++; if (count !== 4'd1 || opcode !== 3'd2 || task_id !== 32'd0 || err_illegal_opcode !== 1'b1)
            begin bad++; $display("FAIL opc_result got count=%0d op=%0d id=%0d err=%b want 1/2/0/1", count, opcode, task_id, err_illegal_opcode); end
`else
        total++; if (count !== 4'd2 || opcode !== 3'd7 || task_id !== 32'd0 || err_illegal_opcode !== 1'b0)
            begin bad++; $display("FAIL opc_result got count=%0d op=%0d id=%0d err=%b want 2/7/0/0", count, opcode, task_id, err_illegal_opcode); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_spurious();
        test_flush();
        test_async_reset();
        test_opcode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
